// File: rtl/ft245_burst_sequencer_if.sv
// rtl/ft245_burst_sequencer_if.sv - FT245 FIFO pin bundle between the burst sequencer and the FIFO/pad side
interface ft245_burst_sequencer_if;
    logic       rxf_n;
    logic       txe_n;
    logic [7:0] usb_data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       rd_n;
    logic       wr_n;

    modport master (
        input  rxf_n,
        input  txe_n,
        input  usb_data_in,
        output data_out,
        output data_oe,
        output rd_n,
        output wr_n
    );

    modport slave (
        output rxf_n,
        output txe_n,
        output usb_data_in,
        input  data_out,
        input  data_oe,
        input  rd_n,
        input  wr_n
    );
endinterface

// File: rtl/ft245_burst_sequencer.sv
// rtl/ft245_burst_sequencer.sv - FT245 FIFO sequencer: host command reads and tagged panel-switch write bursts
// Optional txe_n wait timeout is built only when SEQ_TXE_TIMEOUT_EN is defined.
module ft245_burst_sequencer #(
    parameter int N_NIBBLES      = 4,
    parameter int RD_PULSE       = 2,
    parameter int RD_RECOVER     = 1,
    parameter int WR_SETUP       = 1,
    parameter int WR_PULSE       = 2,
    parameter int WR_HOLD        = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ft245_burst_sequencer_if.master  fifo,
    input  logic                     panel_select_request,
    input  logic [4*N_NIBBLES-1:0]   panel_switches,
    output logic [7:0]               cmd_data,
    output logic                     cmd_valid,
    output logic                     tx_abort,
    output logic                     busy,
    output logic [2:0]               state_out
);

    if (N_NIBBLES < 1 || N_NIBBLES > 15 || RD_PULSE < 1 || RD_RECOVER < 1 ||
        WR_SETUP < 1 || WR_PULSE < 1 || WR_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ft245_burst_sequencer: parameter out of range");
    end

    localparam int MAX_RD  = (RD_PULSE > RD_RECOVER) ? RD_PULSE : RD_RECOVER;
    localparam int MAX_WA  = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
    localparam int MAX_WR  = (MAX_WA > WR_HOLD) ? MAX_WA : WR_HOLD;
    localparam int MAX_CNT = (MAX_RD > MAX_WR) ? MAX_RD : MAX_WR;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       RD_LAST  = cnt_t'(RD_PULSE - 1);
    localparam cnt_t       REC_LAST = cnt_t'(RD_RECOVER - 1);
    localparam cnt_t       SET_LAST = cnt_t'(WR_SETUP - 1);
    localparam cnt_t       STB_LAST = cnt_t'(WR_PULSE - 1);
    localparam cnt_t       HLD_LAST = cnt_t'(WR_HOLD - 1);
    localparam logic [3:0] IDX_LAST = 4'(N_NIBBLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_REC  = 3'd2,
        WR_WAIT = 3'd3,
        WR_SET  = 3'd4,
        WR_STB  = 3'd5,
        WR_HLD  = 3'd6
    } state_t;

    state_t                 state;
    state_t                 state_d;
    cnt_t                   cnt;
    cnt_t                   cnt_d;
    logic [3:0]             idx;
    logic [3:0]             idx_d;
    logic                   pending;
    logic                   pending_d;
    logic [4*N_NIBBLES-1:0] snapshot;
    logic                   snap_load;
    logic                   rd_capture;
    logic                   wait_expired;
    logic [3:0]             nibble;

`ifdef SEQ_TXE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] wait_cnt;

    // Counts consecutive WR_WAIT cycles with txe_n high; any other cycle restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == WR_WAIT && fifo.txe_n) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign wait_expired = (state == WR_WAIT) && fifo.txe_n &&
                          (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tx_abort     = wait_expired;
`else
    assign wait_expired = 1'b0;
    assign tx_abort     = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        idx_d      = idx;
        pending_d  = pending | panel_select_request;
        snap_load  = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                // A request arriving this cycle counts, so writes beat a simultaneous rxf_n.
                if (pending || panel_select_request) begin
                    state_d   = WR_WAIT;
                    idx_d     = 4'd0;
                    snap_load = 1'b1;
                    pending_d = 1'b0;
                end else if (!fifo.rxf_n) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt == RD_LAST) begin
                    rd_capture = 1'b1;
                    cnt_d      = '0;
                    state_d    = RD_REC;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RD_REC: begin
                if (cnt == REC_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WR_WAIT: begin
                cnt_d = '0;
                if (!fifo.txe_n) begin
                    state_d = WR_SET;
                end else if (wait_expired) begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                end
            end
            WR_SET: begin
                if (cnt == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = WR_STB;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WR_STB: begin
                if (cnt == STB_LAST) begin
                    cnt_d   = '0;
                    state_d = WR_HLD;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WR_HLD: begin
                if (cnt == HLD_LAST) begin
                    cnt_d = '0;
                    if (idx == IDX_LAST) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + 4'd1;
                        state_d = WR_WAIT;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= 4'd0;
            pending   <= 1'b0;
            snapshot  <= '0;
            cmd_data  <= 8'h00;
            cmd_valid <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            pending   <= pending_d;
            cmd_valid <= (state == RD_REC) && (cnt == '0);
            if (snap_load) begin
                snapshot <= panel_switches;
            end
            if (rd_capture) begin
                cmd_data <= fifo.usb_data_in;
            end
        end
    end

    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < N_NIBBLES; k++) begin
            if (idx == 4'(k)) begin
                nibble = snapshot[4*k +: 4];
            end
        end
    end

    assign fifo.rd_n     = (state != RD);
    assign fifo.wr_n     = (state != WR_STB);
    assign fifo.data_oe  = (state == WR_SET) || (state == WR_STB) || (state == WR_HLD);
    assign fifo.data_out = fifo.data_oe ? {idx + 4'd1, nibble} : 8'h00;
    assign busy          = (state != IDLE);
    assign state_out     = state;

endmodule

// File: tb/tb_ft245_burst_sequencer.sv
// tb/tb_ft245_burst_sequencer.sv - scoreboard bench for ft245_burst_sequencer with random reads and bursts
module tb_ft245_burst_sequencer;
    localparam int N   = 4;
    localparam int RDP = 2;
    localparam int WRP = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           panel_select_request;
    logic [4*N-1:0] panel_switches;
    logic [7:0]     cmd_data;
    logic           cmd_valid;
    logic           tx_abort;
    logic           busy;
    logic [2:0]     state_out;

    always #5 clk = ~clk;

    ft245_burst_sequencer_if fifo();

    ft245_burst_sequencer #(.N_NIBBLES(N)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .fifo                 (fifo),
        .panel_select_request (panel_select_request),
        .panel_switches       (panel_switches),
        .cmd_data             (cmd_data),
        .cmd_valid            (cmd_valid),
        .tx_abort             (tx_abort),
        .busy                 (busy),
        .state_out            (state_out)
    );

    typedef struct packed {
        logic       is_wr;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not match the expected sequence", name);
    endtask

    // txe_n: mostly ready with random stalls; stall_token requests a 20-cycle stall.
    int stall_token = 0;
    int stall_seen  = 0;
    int stall_left  = 0;
    always @(posedge clk) begin
        #2;
        if (stall_token != stall_seen) begin
            stall_seen = stall_token;
            stall_left = 20;
        end
        if (stall_left > 0) begin
            stall_left--;
            fifo.txe_n = 1'b1;
        end else begin
            fifo.txe_n = ($urandom_range(0, 7) == 0);
        end
    end

    // Monitor: pops the scoreboard on each wr_n strobe and each cmd_valid pulse.
    logic prev_wr, prev_rd;
    int   wr_low, rd_low, since_rd;
    exp_t e;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_wr  = 1'b1;
            prev_rd  = 1'b1;
            wr_low   = 0;
            rd_low   = 0;
            since_rd = -1;
        end else begin
            if (state_out == 3'd3) begin
                check("wait_wr_n", fifo.wr_n, 1'b1);
                check("wait_oe", fifo.data_oe, 1'b0);
                check("wait_data", fifo.data_out, 8'h00);
            end
            if (tx_abort) fail_now("tx_abort");
            if (!fifo.wr_n) begin
                if (prev_wr) begin
                    check("strobe_oe", fifo.data_oe, 1'b1);
                    if (q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        e = q.pop_front();
                        check("write_order", fifo.wr_n, e.is_wr ? 1'b0 : 1'b1);
                        check("write_byte", fifo.data_out, e.val);
                    end
                end
                wr_low++;
            end else if (!prev_wr) begin
                check("wr_pulse_len", wr_low, WRP);
                wr_low = 0;
            end
            if (since_rd >= 0) since_rd++;
            if (!fifo.rd_n) begin
                if (prev_rd) since_rd = 0;
                rd_low++;
            end else if (!prev_rd) begin
                check("rd_pulse_len", rd_low, RDP);
                rd_low = 0;
            end
            if (cmd_valid) begin
                check("cmd_latency", since_rd, RDP + 1);
                since_rd = -1;
                if (q.size() == 0) begin
                    fail_now("unexpected_cmd");
                end else begin
                    e = q.pop_front();
                    check("cmd_order", {31'd0, e.is_wr}, 32'd0);
                    check("cmd_data", cmd_data, e.val);
                end
            end
            prev_wr = fifo.wr_n;
            prev_rd = fifo.rd_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [4*N-1:0] sw);
        for (int k = 0; k < N; k++) begin
            q.push_back('{1'b1, {4'(k + 1), sw[4*k +: 4]}});
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (q.size() == 0 && !busy) break;
            tick();
        end
        if (i == 3000) begin
            fail_now("idle_timeout");
            q.delete();
        end
    endtask

    task automatic wait_rd_start();
        for (int i = 0; i < 3000 && fifo.rd_n; i++) tick();
        if (fifo.rd_n) fail_now("rd_start_timeout");
    endtask

    task automatic wait_wr_fall();
        for (int i = 0; i < 3000 && fifo.wr_n; i++) tick();
        if (fifo.wr_n) fail_now("wr_start_timeout");
    endtask

    task automatic wait_wr_rises(input int n);
        int   seen = 0;
        logic p    = fifo.wr_n;
        for (int i = 0; i < 3000 && seen < n; i++) begin
            tick();
            if (!p && fifo.wr_n) seen++;
            p = fifo.wr_n;
        end
        if (seen < n) fail_now("wr_rise_timeout");
    endtask

    task automatic do_read(input logic [7:0] d);
        fifo.usb_data_in = d;
        fifo.rxf_n = 1'b0;
        q.push_back('{1'b0, d});
        wait_rd_start();
        fifo.rxf_n = 1'b1;
        wait_idle();
    endtask

    task automatic do_write(input logic [4*N-1:0] sw, input bit stall);
        panel_switches = sw;
        push_burst(sw);
        panel_select_request = 1'b1;
        tick();
        panel_select_request = 1'b0;
        wait_wr_fall();
        panel_switches = 16'($urandom);
        if (stall) begin
            wait_wr_rises(2);
            stall_token++;
        end
        wait_idle();
    endtask

    task automatic do_both(input logic [4*N-1:0] sw, input logic [7:0] d);
        panel_switches = sw;
        fifo.usb_data_in = d;
        push_burst(sw);
        q.push_back('{1'b0, d});
        fifo.rxf_n = 1'b0;
        panel_select_request = 1'b1;
        tick();
        panel_select_request = 1'b0;
        wait_rd_start();
        fifo.rxf_n = 1'b1;
        wait_idle();
    endtask

    initial begin
        int i;
        fifo.rxf_n = 1'b1;
        fifo.usb_data_in = 8'h00;
        panel_select_request = 1'b0;
        panel_switches = '0;
        repeat (3) tick();
        check("rst_state", state_out, 3'd0);
        check("rst_rd_n", fifo.rd_n, 1'b1);
        check("rst_wr_n", fifo.wr_n, 1'b1);
        check("rst_oe", fifo.data_oe, 1'b0);
        check("rst_data_out", fifo.data_out, 8'h00);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_data", cmd_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick();

        do_read(8'hA5);
        do_write(16'h9C3E, 1'b1);
        do_both(16'h5A71, 8'h3C);

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 2))
                0: do_read(8'($urandom));
                1: do_write(16'($urandom), $urandom_range(0, 3) == 0);
                default: do_both(16'($urandom), 8'($urandom));
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end

        panel_switches = 16'hBEEF;
        push_burst(16'hBEEF);
        panel_select_request = 1'b1;
        tick();
        panel_select_request = 1'b0;
        for (i = 0; i < 3000 && state_out != 3'd5; i++) tick();
        if (state_out != 3'd5) fail_now("reach_wr_stb");
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_wr_n", fifo.wr_n, 1'b1);
        check("midrst_oe", fifo.data_oe, 1'b0);
        check("midrst_state", state_out, 3'd0);
        check("midrst_data_out", fifo.data_out, 8'h00);
        check("midrst_cmd_data", cmd_data, 8'h00);
        q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("postrst_idle", state_out, 3'd0);
        do_read(8'h96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
